// File: rtl/sw_debounce.sv
// Slide-switch conditioning: 2-FF synchroniser, per-bit debounce, boot-time init window,
// and change reporting (pulse, wrapping event counter, valid flag).
module sw_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  sw_raw,
  input  logic        clr_count,
  output logic [3:0]  SW,
  output logic        sw_changed,
  output logic [15:0] change_count,
  output logic        sw_valid
);

  localparam logic [CNT_W-1:0] InitLast = CNT_W'(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DbLast   = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]            sync1_q, sync1_d;
  logic [3:0]            sync2_q, sync2_d;
  logic [3:0]            sw_q, sw_d;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]      init_cnt_q, init_cnt_d;
  logic                  valid_q, valid_d;
  logic                  changed_q, changed_d;
  logic [15:0]           count_q, count_d;
  logic [3:0]            upd;
  logic                  evt;

  always_comb begin
    sync1_d    = sw_raw;
    sync2_d    = sync1_q;
    sw_d       = sw_q;
    cnt_d      = cnt_q;
    init_cnt_d = init_cnt_q;
    valid_d    = valid_q;
    upd        = '0;

    if (!valid_q) begin
      // Init window: track the synchroniser directly so boot state never looks like a change.
      sw_d       = sync2_q;
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == InitLast) begin
        valid_d = 1'b1;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == sw_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == DbLast) begin
          upd[i]   = 1'b1;
          sw_d[i]  = sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end

    evt       = |upd;
    changed_d = evt;

    if (clr_count) begin
      count_d = evt ? 16'd1 : 16'd0;
    end else if (evt) begin
      count_d = count_q + 16'd1;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      sw_q       <= '0;
      cnt_q      <= '0;
      init_cnt_q <= '0;
      valid_q    <= 1'b0;
      changed_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sw_q       <= sw_d;
      cnt_q      <= cnt_d;
      init_cnt_q <= init_cnt_d;
      valid_q    <= valid_d;
      changed_q  <= changed_d;
      count_q    <= count_d;
    end
  end

  assign SW           = sw_q;
  assign sw_changed   = changed_q;
  assign change_count = count_q;
  assign sw_valid     = valid_q;

endmodule
